fifo_sync_param: RTL

Parametrised single-clock FIFO (storage plus control), the next-generation replacement for the fixed 4-entry FIFO controller in the RFID datapath.
- Generalises data width and depth.
- Adds occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a selectable first-word-fall-through (FWFT) read mode.
- Sits between the demodulator/decoder stages and the command/response framer.

---
 rtl/fifo_pkg.sv | 28 ++
 rtl/fifo_mem.sv | 27 ++
 rtl/fifo_sync_param.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
// Widths are derived per instance from DEPTH via clog2.
package fifo_pkg;

   typedef enum logic {
      MODE_REG  = 1'b0,
      MODE_FWFT = 1'b1
   } rd_mode_e;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      for (int unsigned p = 1; p < v; p = p << 1) begin
         r++;
      end
      return r;
   endfunction

   function automatic bit is_pow2(input int unsigned v);
      return (v >= 2) && ((v & (v - 1)) == 0);
   endfunction

   localparam int unsigned DEF_DEPTH  = 4;
   localparam int unsigned DEF_ADDR_W = clog2(DEF_DEPTH);
   localparam int unsigned DEF_PTR_W  = DEF_ADDR_W + 1;
   localparam int unsigned DEF_CNT_W  = DEF_ADDR_W + 1;

endpackage

// File: rtl/fifo_mem.sv
// DEPTH x DATA_W register array: one synchronous write port, one
// asynchronous read port. Contents are not reset.
module fifo_mem
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 4
) (
   input  logic                       clk_i,
   input  logic                       we_i,
   input  logic [clog2(DEPTH)-1:0]    waddr_i,
   input  logic [DATA_W-1:0]          wdata_i,
   input  logic [clog2(DEPTH)-1:0]    raddr_i,
   output logic [DATA_W-1:0]          rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO control: pointers, occupancy, threshold
// flags, sticky error bits and registered or fall-through read path.
module fifo_sync_param
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned AF_LEVEL = DEPTH - 1,
   parameter int unsigned AE_LEVEL = 1,
   parameter int unsigned FWFT     = 0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    wr_en,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic                    rd_en,
   output logic [DATA_W-1:0]       rd_data,
   output logic                    rd_valid,
   output logic                    full,
   output logic                    empty,
   output logic                    almost_full,
   output logic                    almost_empty,
   output logic [clog2(DEPTH):0]   count,
   output logic                    overflow,
   output logic                    underflow,
   input  logic                    clear_err
);

   localparam int unsigned ADDR_W = clog2(DEPTH);
   localparam int unsigned PTR_W  = ADDR_W + 1;
   localparam rd_mode_e    MODE   = (FWFT != 0) ? MODE_FWFT : MODE_REG;
   localparam logic [PTR_W-1:0] AF_TH = PTR_W'(AF_LEVEL);
   localparam logic [PTR_W-1:0] AE_TH = PTR_W'(AE_LEVEL);

   if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("fifo_sync_param: DEPTH must be a power of two >= 2");
   end
   if (AF_LEVEL > DEPTH) begin : g_bad_af
      $error("fifo_sync_param: AF_LEVEL must not exceed DEPTH");
   end
   if (AE_LEVEL >= DEPTH) begin : g_bad_ae
      $error("fifo_sync_param: AE_LEVEL must be below DEPTH");
   end
   if (DATA_W < 1) begin : g_bad_width
      $error("fifo_sync_param: DATA_W must be at least 1");
   end

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]  cnt_q, cnt_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              rvalid_q, rvalid_d;

   logic              full_s, empty_s;
   logic              wr_acc, rd_acc;
   logic [DATA_W-1:0] mem_rdata;

   fifo_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk_i   (clock),
      .we_i    (wr_acc),
      .waddr_i (wr_ptr_q[ADDR_W-1:0]),
      .wdata_i (wr_data),
      .raddr_i (rd_ptr_q[ADDR_W-1:0]),
      .rdata_o (mem_rdata)
   );

   // A read frees a slot in the same edge, so a full FIFO still takes a write.
   always_comb begin
      full_s  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
      empty_s = (wr_ptr_q == rd_ptr_q);
      rd_acc  = rd_en & ~empty_s;
      wr_acc  = wr_en & (~full_s | rd_acc);
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({wr_acc, rd_acc})
         2'b10:   cnt_d = cnt_q + PTR_W'(1);
         2'b01:   cnt_d = cnt_q - PTR_W'(1);
         default: cnt_d = cnt_q;
      endcase

      // A new error in the same cycle as clear_err keeps the flag set.
      ovf_d = (wr_en & ~wr_acc) ? 1'b1 : (clear_err ? 1'b0 : ovf_q);
      unf_d = (rd_en & ~rd_acc) ? 1'b1 : (clear_err ? 1'b0 : unf_q);

      rdata_d  = rdata_q;
      rvalid_d = 1'b0;
      if ((MODE == MODE_REG) && rd_acc) begin
         rdata_d  = mem_rdata;
         rvalid_d = 1'b1;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
         rdata_q  <= rdata_d;
         rvalid_q <= rvalid_d;
      end
   end

   always_comb begin
      full         = full_s;
      empty        = empty_s;
      almost_full  = (cnt_q >= AF_TH);
      almost_empty = (cnt_q <= AE_TH);
      count        = cnt_q;
      overflow     = ovf_q;
      underflow    = unf_q;
      if (MODE == MODE_FWFT) begin
         rd_valid = ~empty_s;
         rd_data  = empty_s ? '0 : mem_rdata;
      end else begin
         rd_valid = rvalid_q;
         rd_data  = rdata_q;
      end
   end

endmodule
